// File: rtl/in_port_fifo_if.sv
// ============================================================================
// in_port_fifo_if : producer handshake and CPU-side read bus of the input port
// Rev 1.0
// ============================================================================
`default_nettype none

interface in_port_fifo_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 3
);
   logic [DATA_W-1:0] ext_data;
   logic              ext_valid;
   logic              ext_ready;
   logic              InPortOut;
   logic [DATA_W-1:0] BusMuxInPort;
   logic              in_empty;
   logic              in_full;
   logic [CNT_W-1:0]  in_count;
   logic              underflow;

   modport slave (
      input  ext_data, ext_valid, InPortOut,
      output ext_ready, BusMuxInPort, in_empty, in_full, in_count, underflow
   );

   modport master (
      output ext_data, ext_valid, InPortOut,
      input  ext_ready, BusMuxInPort, in_empty, in_full, in_count, underflow
   );
endinterface

`default_nettype wire

// File: rtl/in_port_fifo.sv
// ============================================================================
// in_port_fifo : input-port FIFO for the "in" instruction, edge-detected pop
// Rev 1.0
// ============================================================================
`default_nettype none

module in_port_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 3
) (
   input  wire logic      clock,
   input  wire logic      clear,
   in_port_fifo_if.slave  port
);
   localparam int c_PTR_W = CNT_W - 1;

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_strobe_d;
   logic               r_underflow;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop_req;
   logic w_pop;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_push    = port.ext_valid && !w_full;
   // Only the first cycle of a held strobe counts as a read request.
   assign w_pop_req = port.InPortOut && !r_strobe_d;
   assign w_pop     = w_pop_req && !w_empty;

   assign port.ext_ready    = !w_full;
   assign port.in_empty     = w_empty;
   assign port.in_full      = w_full;
   assign port.in_count     = r_count;
   assign port.underflow    = r_underflow;
   assign port.BusMuxInPort = w_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= port.ext_data;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_strobe_d  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_strobe_d <= port.InPortOut;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         if (w_pop_req && w_empty) begin
            r_underflow <= 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

`default_nettype wire
